// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a combinational instruction
// memory and registers the fetched word into the IF/ID pipeline register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4_s;

  assign pc_plus4_s = pc_q + 32'd4;

  // Next-state selection: redirect beats stall, stall beats normal advance.
  always_comb begin
    pc_d            = pc_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_count_d   = fetch_count_q;
    if (redirect_valid) begin
      pc_d            = {redirect_target[31:2], 2'b00};
      ifid_pc_d       = 32'h0000_0000;
      ifid_pc_plus4_d = 32'h0000_0000;
      ifid_instr_d    = NOP_INSTR;
      ifid_valid_d    = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d            = pc_plus4_s;
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_plus4_s;
      ifid_instr_d    = imem_instr;
      ifid_valid_d    = 1'b1;
      fetch_count_d   = fetch_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= {RESET_PC[31:2], 2'b00};
      ifid_pc_q       <= 32'h0000_0000;
      ifid_pc_plus4_q <= 32'h0000_0000;
      ifid_instr_q    <= NOP_INSTR;
      ifid_valid_q    <= 1'b0;
      fetch_count_q   <= 32'h0000_0000;
    end else begin
      pc_q            <= pc_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign imem_pc       = pc_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_valid    = ifid_valid_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small combinational memory model.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  int n_checks;
  int n_errors;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_instr     (ifid_instr),
    .ifid_valid     (ifid_valid),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three-word program; anything else reads back as a NOP.
  always_comb begin
    case (imem_pc)
      32'h0000_0000: imem_instr = 32'h0010_0093;
      32'h0000_0004: imem_instr = 32'h0020_0113;
      32'h0000_0008: imem_instr = 32'h0020_81B3;
      default:       imem_instr = 32'h0000_0013;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic valid, input logic [31:0] cnt);
    check({tag, ".ifid_pc"}, ifid_pc, pc);
    check({tag, ".ifid_pc_plus4"}, ifid_pc_plus4, valid ? pc + 32'd4 : 32'd0);
    check({tag, ".ifid_instr"}, ifid_instr, instr);
    check({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    check({tag, ".fetch_count"}, fetch_count, cnt);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0000_0000;

    // Reset held for two cycles
    tick();
    tick();
    check("rst.imem_pc", imem_pc, 32'h0000_0000);
    check_ifid("rst", 32'h0, 32'h0000_0013, 1'b0, 32'd0);

    // Sequential fetch
    rst = 1'b0;
    tick();
    check_ifid("seq1", 32'h0, 32'h0010_0093, 1'b1, 32'd1);
    check("seq1.imem_pc", imem_pc, 32'h4);
    tick();
    check_ifid("seq2", 32'h4, 32'h0020_0113, 1'b1, 32'd2);
    tick();
    check_ifid("seq3", 32'h8, 32'h0020_81B3, 1'b1, 32'd3);
    check("seq3.imem_pc", imem_pc, 32'hC);

    // Stall for three cycles with imem_pc at 8
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("pre_stall.imem_pc", imem_pc, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.imem_pc", imem_pc, 32'h8);
      check_ifid("stall", 32'h4, 32'h0020_0113, 1'b1, 32'd2);
    end
    stall = 1'b0;
    tick();
    check_ifid("unstall", 32'h8, 32'h0020_81B3, 1'b1, 32'd3);

    // Redirect wins over stall; target low bits are cleared
    redirect_valid = 1'b1;
    stall = 1'b1;
    redirect_target = 32'h0000_0042;
    tick();
    check("redir.imem_pc", imem_pc, 32'h40);
    check_ifid("redir", 32'h0, 32'h0000_0013, 1'b0, 32'd3);
    redirect_valid = 1'b0;
    stall = 1'b0;
    tick();
    check_ifid("post_redir", 32'h40, 32'h0000_0013, 1'b1, 32'd4);
    check("post_redir.imem_pc", imem_pc, 32'h44);

    // Wrap-around at the top of the address space
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    tick();
    check("wrap_redir.imem_pc", imem_pc, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick();
    check("wrap.imem_pc", imem_pc, 32'h0);
    check("wrap.ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    check("wrap.ifid_pc_plus4", ifid_pc_plus4, 32'h0);
    check("wrap.ifid_instr", ifid_instr, 32'h0000_0013);
    check("wrap.ifid_valid", {31'd0, ifid_valid}, 32'd1);
    check("wrap.fetch_count", fetch_count, 32'd5);
    tick();
    check_ifid("after_wrap", 32'h0, 32'h0010_0093, 1'b1, 32'd6);

    // Reset asserted together with stall
    stall = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_stall.imem_pc", imem_pc, 32'h0);
    check_ifid("rst_stall", 32'h0, 32'h0000_0013, 1'b0, 32'd0);

    // Reset asserted together with redirect
    stall = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check("pre_rst_redir.fetch_count", fetch_count, 32'd2);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    check("rst_redir.imem_pc", imem_pc, 32'h0);
    check_ifid("rst_redir", 32'h0, 32'h0000_0013, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the bubble instruction.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 stall  input  1  when high, holds the PC and the IF/ID register.
REQ-006 redirect_valid  input  1  when high, requests a branch/jump redirect.
REQ-007 redirect_target  input  32  is the redirect destination address.
REQ-008 imem_pc  output  32  is the fetch address driven to the combinational instruction memory.
REQ-009 imem_instr  input  32  is the instruction word returned by the instruction memory for imem_pc in the same cycle.
REQ-010 ifid_pc  output  32  is the PC of the instruction held in IF/ID.
REQ-011 ifid_pc_plus4  output  32  is ifid_pc + 4, truncated to 32 bits.
REQ-012 ifid_instr  output  32  is the instruction held in IF/ID.
REQ-013 ifid_valid  output  1  when high, means IF/ID holds a real fetched instruction, not a bubble.
REQ-014 fetch_count  output  32  counts instructions accepted into IF/ID.

Function
REQ-015 imem_pc SHALL be driven directly from the internal PC register (no combinational path from inputs).
REQ-016 Per-edge priority SHALL be: rst > redirect_valid > stall > normal advance.
REQ-017 Normal advance (rst=0, redirect_valid=0, stall=0) SHALL update on the edge as follows:
- PC <= PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- IF/ID <= {ifid_pc=PC, ifid_pc_plus4=PC+4, ifid_instr=imem_instr, ifid_valid=1}.
- fetch_count <= fetch_count + 1, wrapping modulo 2^32.
REQ-018 Redirect (redirect_valid=1, rst=0) SHALL update on the edge as follows, regardless of stall:
- PC <= {redirect_target[31:2], 2'b00}.
- IF/ID <= bubble (ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc and ifid_pc_plus4 = 0).
- fetch_count unchanged.
REQ-019 Stall (stall=1, redirect_valid=0, rst=0) SHALL hold PC, all IF/ID fields and fetch_count unchanged.
REQ-020 Fetch-to-IF/ID latency SHALL be one cycle: an instruction addressed by imem_pc in cycle N appears on the ifid_* outputs in cycle N+1.
REQ-021 imem_instr SHALL be captured unmodified; a NOP returned for an out-of-range PC is treated as a valid instruction (ifid_valid=1).
REQ-022 The PC low two bits SHALL always be 2'b00.
REQ-023 Holding stall high for any number of cycles SHALL lose no instruction; the instruction captured before the stall remains in IF/ID throughout.

Reset
REQ-024 On a rising edge with rst=1, the block SHALL load:
- PC = RESET_PC.
- ifid_instr = NOP_INSTR, ifid_valid = 0, ifid_pc = 0, ifid_pc_plus4 = 0.
- fetch_count = 0.
REQ-025 rst SHALL override stall and redirect_valid in the same cycle, including when asserted mid-stall or mid-redirect.
REQ-026 Outputs before the first reset edge are undefined; the bench SHALL apply rst for at least 1 cycle.

Verification
REQ-027 Reset: hold rst=1 for 2 cycles -> imem_pc=0, ifid_valid=0, ifid_instr=00000013, fetch_count=0.
REQ-028 Sequential fetch: memory holds 00100093, 00200113, 002081B3 at 0/4/8; release rst -> over cycles 1/2/3 ifid_instr=00100093/00200113/002081B3, ifid_pc=0/4/8, ifid_pc_plus4=4/8/C, fetch_count=1/2/3.
REQ-029 Stall: stall=1 for 3 cycles with imem_pc=8 -> imem_pc stays 8, ifid_pc stays 4, fetch_count frozen; on release, ifid_pc=8 on the next edge.
REQ-030 Redirect with stall: redirect_valid=1, stall=1, redirect_target=32'h0000_0042 -> next edge imem_pc=40, ifid_valid=0, ifid_instr=00000013; the following edge ifid_pc=40, ifid_valid=1.
REQ-031 Wrap-around: redirect to FFFF_FFFC, then advance -> imem_pc=0, ifid_pc=FFFF_FFFC, ifid_pc_plus4=0, ifid_instr=00000013 (out-of-range NOP), ifid_valid=1.
REQ-032 Reset mid-stall: stall=1 and rst=1 on the same edge -> imem_pc=RESET_PC, ifid_valid=0, fetch_count=0.
